uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit.
// The rx pin is double-flopped, and each bit is sampled at its centre relative to the start edge.
module uart_rx #(
  parameter int CLOCKS_PER_PULSE = 16,
  parameter int DATA_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int H  = CLOCKS_PER_PULSE / 2;
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] C_HALF = CW'(H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  logic                  rx_m;
  logic                  rx_s;
  logic [2:0]            state;
  logic [CW-1:0]         c_clocks;
  logic [BW-1:0]         c_bits;
  logic [DATA_WIDTH-1:0] shreg;

  // NOTE: the synchronizer resets to the idle-high line level so that reset release
  // can never look like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // NOTE: all state here uses non-blocking assignments, so every branch reads the
  // values from before the edge. The pulses default low and are raised only for one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RX_IDLE;
      c_clocks   <= '0;
      c_bits     <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            c_clocks <= '0;
          end
        end
        RX_START: begin
          if (c_clocks == C_HALF) begin
            if (!rx_s) begin
              state    <= RX_DATA;
              c_clocks <= '0;
              c_bits   <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            c_clocks <= c_clocks + 1'b1;
          end
        end
        RX_DATA: begin
          if (c_clocks == C_LAST) begin
            c_clocks      <= '0;
            shreg[c_bits] <= rx_s;
            if (c_bits == B_LAST) begin
              state <= RX_STOP;
            end else begin
              c_bits <= c_bits + 1'b1;
            end
          end else begin
            c_clocks <= c_clocks + 1'b1;
          end
        end
        RX_STOP: begin
          // Leave at mid-stop so a start bit directly after a one-bit stop is caught.
          if (c_clocks == C_LAST) begin
            c_clocks <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_BREAK;
            end
          end else begin
            c_clocks <= c_clocks + 1'b1;
          end
        end
        RX_BREAK: begin
          // Wait out a held-low line rather than retriggering on it.
          if (rx_s) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with default parameters (16 clocks per bit, 8 data bits).
// The clock period is 10 time units, and rx is always driven from a falling clock edge.
module tb_uart_rx;

  logic       clk;
  logic       rstn;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, busy_cnt = 0;
  int         dv_cyc = 0, dv_cyc_prev = 0, fe_cyc = 0;
  logic [7:0] dv_data = 8'h00, dv_data_prev = 8'h00;

  uart_rx dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (data_valid) begin
        dv_cnt       <= dv_cnt + 1;
        dv_cyc_prev  <= dv_cyc;
        dv_cyc       <= cyc;
        dv_data_prev <= dv_data;
        dv_data      <= data_out;
      end
      if (frame_err) begin
        fe_cnt <= fe_cnt + 1;
        fe_cyc <= cyc;
      end
      if (data_valid && frame_err) both_cnt <= both_cnt + 1;
      if (rx_busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a falling edge and drives one frame with bit_t time units per bit.
  // The stop bit level is given by stop, and the task returns with rx still at that level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_t);
    rx = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_t);
    end
    rx = stop;
    #(bit_t);
  endtask

  logic [7:0] skew_words [3] = '{8'h01, 8'h80, 8'h55};
  int         skew_bits  [2] = '{152, 168};

  initial begin
    int t0, dv_b, fe_b, busy_b;

    rx   = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_rx_busy", 32'(rx_busy), 32'h0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Ideal 0xA5 frame: the pulse comes 2 synchronizer cycles plus 153 cycles after the edge.
    dv_b = dv_cnt; fe_b = fe_cnt; t0 = cyc;
    send_frame(8'hA5, 1'b1, 160);
    repeat (20) @(negedge clk);
    check("a5_dv_count", 32'(dv_cnt - dv_b), 32'd1);
    check("a5_dv_cycle", 32'(dv_cyc - t0), 32'd155);
    check("a5_dv_data", 32'(dv_data), 32'hA5);
    check("a5_data_out", 32'(data_out), 32'hA5);
    check("a5_no_fe", 32'(fe_cnt - fe_b), 32'd0);

    // A 4-cycle glitch is rejected at mid-start after 8 busy cycles.
    dv_b = dv_cnt; fe_b = fe_cnt; busy_b = busy_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy_cycles", 32'(busy_cnt - busy_b), 32'd8);
    check("glitch_no_dv", 32'(dv_cnt - dv_b), 32'd0);
    check("glitch_no_fe", 32'(fe_cnt - fe_b), 32'd0);
    dv_b = dv_cnt;
    send_frame(8'h3C, 1'b1, 160);
    repeat (20) @(negedge clk);
    check("3c_dv_count", 32'(dv_cnt - dv_b), 32'd1);
    check("3c_data_out", 32'(data_out), 32'h3C);

    // Stop bit low, then the line is held low for 40 more cycles.
    dv_b = dv_cnt; fe_b = fe_cnt; t0 = cyc;
    send_frame(8'hC3, 1'b0, 160);
    repeat (40) @(negedge clk);
    check("break_busy_low_line", 32'(rx_busy), 32'h1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_idle_after_high", 32'(rx_busy), 32'h0);
    repeat (200) @(negedge clk);
    check("fe_count", 32'(fe_cnt - fe_b), 32'd1);
    check("fe_cycle", 32'(fe_cyc - t0), 32'd155);
    check("fe_no_dv", 32'(dv_cnt - dv_b), 32'd0);
    check("fe_data_kept", 32'(data_out), 32'h3C);

    // Back-to-back frames with no idle gap.
    dv_b = dv_cnt; fe_b = fe_cnt; t0 = cyc;
    send_frame(8'h00, 1'b1, 160);
    send_frame(8'hFF, 1'b1, 160);
    repeat (20) @(negedge clk);
    check("b2b_dv_count", 32'(dv_cnt - dv_b), 32'd2);
    check("b2b_first_data", 32'(dv_data_prev), 32'h00);
    check("b2b_second_data", 32'(dv_data), 32'hFF);
    check("b2b_spacing", 32'(dv_cyc - dv_cyc_prev), 32'd160);
    check("b2b_second_cycle", 32'(dv_cyc - t0), 32'd315);
    check("b2b_no_fe", 32'(fe_cnt - fe_b), 32'd0);

    // Reset in the middle of data bit 3 of 0x81.
    dv_b = dv_cnt; fe_b = fe_cnt;
    rx = 1'b0; #160;
    rx = 1'b1; #160;
    rx = 1'b0; #160;
    rx = 1'b0; #160;
    rx = 1'b0; #80;
    check("midrst_busy_before", 32'(rx_busy), 32'h1);
    rstn = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_data_valid", 32'(data_valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_rx_busy", 32'(rx_busy), 32'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_dv", 32'(dv_cnt - dv_b), 32'd0);
    check("midrst_no_fe", 32'(fe_cnt - fe_b), 32'd0);
    dv_b = dv_cnt;
    send_frame(8'h5A, 1'b1, 160);
    repeat (20) @(negedge clk);
    check("5a_dv_count", 32'(dv_cnt - dv_b), 32'd1);
    check("5a_data_out", 32'(data_out), 32'h5A);

    // Bit periods are skewed by +/-5% (152 and 168 time units instead of 160).
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 3; w++) begin
        dv_b = dv_cnt; fe_b = fe_cnt;
        send_frame(skew_words[w], 1'b1, skew_bits[r]);
        repeat (20) @(negedge clk);
        check($sformatf("skew%0d_%02h_dv_count", skew_bits[r], skew_words[w]),
              32'(dv_cnt - dv_b), 32'd1);
        check($sformatf("skew%0d_%02h_data", skew_bits[r], skew_words[w]),
              32'(data_out), 32'(skew_words[w]));
        check($sformatf("skew%0d_%02h_no_fe", skew_bits[r], skew_words[w]),
              32'(fe_cnt - fe_b), 32'd0);
      end
    end

    check("pulses_exclusive", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
